// File: rtl/rom_header_sniffer_if.sv
// HPS ioctl download stream as seen by the ROM header sniffer.
// The sniffer only listens; the HPS side drives every signal.
interface rom_header_sniffer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_dout
  );
endinterface

// File: rtl/rom_header_sniffer.sv
// Snoops SNES ROM downloads, captures header candidates and publishes
// map type, ROM/RAM masks and region once the download ends.
module rom_header_sniffer #(
  parameter logic [3:0] DEF_ROM_SIZE = 4'hC,
  parameter logic [3:0] MAX_RAM_SIZE = 4'h7
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  rom_header_sniffer_if.slave  ioctl,
  input  logic [2:0]           force_type,
  output logic                 busy,
  output logic                 done,
  output logic                 hdr_off,
  output logic [7:0]           rom_type,
  output logic [23:0]          rom_mask,
  output logic [23:0]          ram_mask,
  output logic                 rom_region,
  output logic                 score_ok
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SIZE,
    S_EVAL0,
    S_EVAL1,
    S_EVAL2,
    S_APPLY
  } state_t;

  // 64-byte block of each slot: {Lo,Hi,ExHi} then the same +200h
  localparam logic [18:0] SLOT_BLK [6] = '{
    19'h001FF, 19'h003FF, 19'h103FF,
    19'h00207, 19'h00407, 19'h10407
  };

  localparam int F_MAP    = 0;
  localparam int F_CHIP   = 1;
  localparam int F_ROMSZ  = 2;
  localparam int F_RAMSZ  = 3;
  localparam int F_REGION = 4;
  localparam int F_CMPL_L = 7;
  localparam int F_CMPL_H = 8;
  localparam int F_CSUM_L = 9;
  localparam int F_CSUM_H = 10;

  state_t state, state_nx;

  logic        dl_q;
  logic        dl_rise;
  logic [7:0]  cap [6][16];
  logic [9:0]  last_lo;
  logic [9:0]  len_lo;
  logic        sel_h;
  logic [1:0]  best_k;
  logic [2:0]  best_score;

  logic [18:0] blk;
  logic [5:0]  a0;
  logic [5:0]  a1;
  logic        in0;
  logic        in1;
  logic [3:0]  i0;
  logic [3:0]  i1;
  logic [5:0]  slot_hit;
  logic        cap_we;

  logic [1:0]  eval_k;
  logic [2:0]  eval_s;
  logic [2:0]  eval_score;

  logic [1:0]  win_k;
  logic [2:0]  win_s;
  logic [7:0]  w_romsz;
  logic [7:0]  w_ramsz;
  logic [7:0]  w_region;
  logic [3:0]  rom_code;
  logic [23:0] rom_mask_nx;
  logic [23:0] ram_mask_nx;
  logic        region_nx;
  logic        csum_ok_nx;

  function automatic logic [2:0] slot_of(
    input logic       h,
    input logic [1:0] k
  );
    return h ? ({1'b0, k} + 3'd3) : {1'b0, k};
  endfunction

  function automatic logic romsz_ok(input logic [7:0] sz);
    return (sz >= 8'h08) && (sz <= 8'h0D);
  endfunction

  function automatic logic [7:0] map_code(input logic [1:0] k);
    logic [7:0] c;
    c = 8'h20;
    unique case (1'b1)
      k == 2'd1: c = 8'h21;
      k == 2'd2: c = 8'h25;
      default:   c = 8'h20;
    endcase
    return c;
  endfunction

  // Score bits line up with weights 4 (checksum), 2 (map), 1 (size)
  function automatic logic [2:0] score_of(
    input logic [1:0]  k,
    input logic [7:0]  map,
    input logic [7:0]  romsz,
    input logic [15:0] csum,
    input logic [15:0] cmpl
  );
    return {(csum ^ cmpl) == 16'hFFFF,
            (map & 8'hEF) == map_code(k),
            romsz_ok(romsz)};
  endfunction

  assign dl_rise = ioctl.ioctl_download & ~dl_q;
  assign len_lo  = last_lo + 10'd2;

  // Byte address decode for both halves of the incoming word
  assign blk = ioctl.ioctl_addr[24:6];
  assign a0  = ioctl.ioctl_addr[5:0];
  assign a1  = ioctl.ioctl_addr[5:0] | 6'h01;
  assign in0 = (a0[5:4] == 2'b01) && (a0[3:0] >= 4'h5);
  assign in1 = (a1[5:4] == 2'b01) && (a1[3:0] >= 4'h5);
  assign i0  = a0[3:0] - 4'h5;
  assign i1  = a1[3:0] - 4'h5;

  always_comb begin
    slot_hit = '0;
    for (int s = 0; s < 6; s++) begin
      slot_hit[s] = (blk == SLOT_BLK[s]);
    end
  end

  assign cap_we = (state == S_LOAD) && ioctl.ioctl_wr && !dl_rise;

  always_ff @(posedge clk_sys) begin
    if (reset || dl_rise) begin
      for (int s = 0; s < 6; s++) begin
        for (int i = 0; i < 16; i++) begin
          cap[s][i] <= '0;
        end
      end
    end else if (cap_we) begin
      for (int s = 0; s < 6; s++) begin
        if (slot_hit[s]) begin
          if (in0) cap[s][i0] <= ioctl.ioctl_dout[7:0];
          if (in1) cap[s][i1] <= ioctl.ioctl_dout[15:8];
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (dl_rise) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_IDLE;
        S_LOAD:  if (!ioctl.ioctl_download) state_nx = S_SIZE;
        S_SIZE:  state_nx = S_EVAL0;
        S_EVAL0: state_nx = S_EVAL1;
        S_EVAL1: state_nx = S_EVAL2;
        S_EVAL2: state_nx = S_APPLY;
        S_APPLY: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    eval_k = 2'd0;
    unique case (1'b1)
      state == S_EVAL1: eval_k = 2'd1;
      state == S_EVAL2: eval_k = 2'd2;
      default:          eval_k = 2'd0;
    endcase
    eval_s     = slot_of(sel_h, eval_k);
    eval_score = score_of(eval_k,
                          cap[eval_s][F_MAP],
                          cap[eval_s][F_ROMSZ],
                          {cap[eval_s][F_CSUM_H], cap[eval_s][F_CSUM_L]},
                          {cap[eval_s][F_CMPL_H], cap[eval_s][F_CMPL_L]});
  end

  // Forced map types bypass the scoring winner
  always_comb begin
    win_k = best_k;
    unique case (1'b1)
      force_type == 3'd2: win_k = 2'd0;
      force_type == 3'd3: win_k = 2'd1;
      force_type == 3'd4: win_k = 2'd2;
      default:            win_k = best_k;
    endcase
    win_s    = slot_of(sel_h, win_k);
    w_romsz  = cap[win_s][F_ROMSZ];
    w_ramsz  = cap[win_s][F_RAMSZ];
    w_region = cap[win_s][F_REGION];

    rom_code    = romsz_ok(w_romsz) ? w_romsz[3:0] : DEF_ROM_SIZE;
    rom_mask_nx = (24'd1024 << rom_code) - 24'd1;

    ram_mask_nx = 24'd0;
    if ((w_ramsz != 8'h00) && (w_ramsz <= {4'h0, MAX_RAM_SIZE})) begin
      ram_mask_nx = (24'd1024 << w_ramsz[3:0]) - 24'd1;
    end

    region_nx = ((w_region >= 8'h02) && (w_region <= 8'h0C)) ||
                (w_region == 8'h11);
    csum_ok_nx = ({cap[win_s][F_CSUM_H], cap[win_s][F_CSUM_L]} ^
                  {cap[win_s][F_CMPL_H], cap[win_s][F_CMPL_L]}) == 16'hFFFF;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      last_lo    <= '0;
      sel_h      <= 1'b0;
      best_k     <= '0;
      best_score <= '0;
      hdr_off    <= 1'b0;
      rom_type   <= '0;
      rom_mask   <= 24'h3FFFFF;
      ram_mask   <= '0;
      rom_region <= 1'b0;
      score_ok   <= 1'b0;
    end else begin
      state <= state_nx;
      dl_q  <= ioctl.ioctl_download;
      busy  <= (state_nx != S_IDLE);
      done  <= (state == S_APPLY) && !dl_rise;

      if (dl_rise) begin
        last_lo <= '0;
      end else if (cap_we) begin
        last_lo <= ioctl.ioctl_addr[9:0];
      end

      if ((state == S_SIZE) && !dl_rise) begin
        sel_h <= (force_type == 3'd1) ? 1'b0 : (len_lo == 10'h200);
      end

      // Strictly greater wins, so ties keep the lower map type
      if (!dl_rise) begin
        if (state == S_EVAL0) begin
          best_k     <= 2'd0;
          best_score <= eval_score;
        end else if (((state == S_EVAL1) || (state == S_EVAL2)) &&
                     (eval_score > best_score)) begin
          best_k     <= eval_k;
          best_score <= eval_score;
        end
      end

      if ((state == S_APPLY) && !dl_rise) begin
        hdr_off    <= sel_h;
        rom_type   <= {cap[win_s][F_CHIP][7:4], 2'b00, win_k};
        rom_mask   <= rom_mask_nx;
        ram_mask   <= ram_mask_nx;
        rom_region <= region_nx;
        score_ok   <= csum_ok_nx;
      end
    end
  end

endmodule

// File: tb/tb_rom_header_sniffer.sv
// Scoreboard bench for rom_header_sniffer: the driver queues expected
// results, a negedge monitor checks them whenever done pulses.
module tb_rom_header_sniffer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [2:0]  force_type;
  logic        busy;
  logic        done;
  logic        hdr_off;
  logic [7:0]  rom_type;
  logic [23:0] rom_mask;
  logic [23:0] ram_mask;
  logic        rom_region;
  logic        score_ok;

  rom_header_sniffer_if ioctl ();

  always #5 clk_sys = ~clk_sys;

  rom_header_sniffer dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ioctl      (ioctl),
    .force_type (force_type),
    .busy       (busy),
    .done       (done),
    .hdr_off    (hdr_off),
    .rom_type   (rom_type),
    .rom_mask   (rom_mask),
    .ram_mask   (ram_mask),
    .rom_region (rom_region),
    .score_ok   (score_ok)
  );

  typedef struct {
    string       name;
    logic        hdr_off;
    logic [7:0]  rom_type;
    logic [23:0] rom_mask;
    logic [23:0] ram_mask;
    logic        rom_region;
    logic        score_ok;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  task automatic push(input string n, input logic h, input logic [7:0] t,
                      input logic [23:0] rm, input logic [23:0] am,
                      input logic rg, input logic ok);
    exp_t e;
    e.name = n; e.hdr_off = h; e.rom_type = t;
    e.rom_mask = rm; e.ram_mask = am; e.rom_region = rg; e.score_ok = ok;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk_sys) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".hdr_off"}, hdr_off, e.hdr_off);
        check({e.name, ".rom_type"}, rom_type, e.rom_type);
        check({e.name, ".rom_mask"}, rom_mask, e.rom_mask);
        check({e.name, ".ram_mask"}, ram_mask, e.ram_mask);
        check({e.name, ".rom_region"}, rom_region, e.rom_region);
        check({e.name, ".score_ok"}, score_ok, e.score_ok);
      end
    end
  end

  task automatic wr_word(input logic [24:0] a, input logic [15:0] d);
    @(negedge clk_sys);
    ioctl.ioctl_wr   = 1'b1;
    ioctl.ioctl_addr = a;
    ioctl.ioctl_dout = d;
    @(negedge clk_sys);
    ioctl.ioctl_wr   = 1'b0;
  endtask

  task automatic wr_hdr(input logic [24:0] base, input logic [7:0] map,
                        input logic [7:0] chip, input logic [7:0] romsz,
                        input logic [7:0] ramsz, input logic [7:0] region,
                        input logic [15:0] csum, input logic [15:0] cmpl);
    wr_word(base + 25'h14, {map, 8'h00});
    wr_word(base + 25'h16, {romsz, chip});
    wr_word(base + 25'h18, {region, ramsz});
    wr_word(base + 25'h1A, 16'h0000);
    wr_word(base + 25'h1C, cmpl);
    wr_word(base + 25'h1E, csum);
  endtask

  task automatic start_dl();
    @(negedge clk_sys);
    ioctl.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_dl(input logic [24:0] len);
    wr_word(len - 25'd2, 16'h0000);
    @(negedge clk_sys);
    ioctl.ioctl_download = 1'b0;
    repeat (6) @(posedge clk_sys);
    #1;
    check("done_latency", done, 1'b1);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic chk_reset(input string n);
    check({n, ".busy"}, busy, 1'b0);
    check({n, ".done"}, done, 1'b0);
    check({n, ".hdr_off"}, hdr_off, 1'b0);
    check({n, ".rom_type"}, rom_type, 8'h00);
    check({n, ".rom_mask"}, rom_mask, 24'h3FFFFF);
    check({n, ".ram_mask"}, ram_mask, 24'h000000);
    check({n, ".rom_region"}, rom_region, 1'b0);
    check({n, ".score_ok"}, score_ok, 1'b0);
  endtask

  task automatic case1_image();
    wr_hdr(25'h0081C0, 8'h20, 8'h35, 8'h09, 8'h03, 8'h01, 16'h1234, 16'hEDCB);
  endtask

  task automatic hirom_image();
    wr_hdr(25'h007FC0, 8'h77, 8'h00, 8'hFF, 8'hFF, 8'hFF, 16'h1111, 16'h2222);
    wr_hdr(25'h00FFC0, 8'h21, 8'h12, 8'h0B, 8'h00, 8'h02, 16'hABCD, 16'h5432);
  endtask

  initial begin
    reset                = 1'b1;
    force_type           = 3'd0;
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_wr       = 1'b0;
    ioctl.ioctl_addr     = '0;
    ioctl.ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);
    chk_reset("reset");
    reset = 1'b0;

    // LoROM with copier header
    push("lorom_copier", 1'b1, 8'h30, 24'h07FFFF, 24'h001FFF, 1'b0, 1'b1);
    start_dl();
    check("busy_in_load", busy, 1'b1);
    case1_image();
    end_dl(25'h080200);

    // HiROM, garbage LoROM slot
    push("hirom", 1'b0, 8'h11, 24'h1FFFFF, 24'h000000, 1'b1, 1'b1);
    start_dl();
    hirom_image();
    end_dl(25'h200000);

    // ExHiROM beats a LoROM slot with bad checksum
    push("exhirom", 1'b0, 8'hF2, 24'h7FFFFF, 24'h007FFF, 1'b0, 1'b1);
    start_dl();
    wr_hdr(25'h007FC0, 8'h20, 8'h00, 8'h0C, 8'h00, 8'h00, 16'h0000, 16'h0000);
    wr_hdr(25'h40FFC0, 8'h25, 8'hF5, 8'h0D, 8'h05, 8'h00, 16'h8001, 16'h7FFE);
    end_dl(25'h600000);

    // Forced HiROM reads an empty slot
    force_type = 3'd3;
    push("force_hirom", 1'b1, 8'h01, 24'h3FFFFF, 24'h000000, 1'b0, 1'b0);
    start_dl();
    case1_image();
    end_dl(25'h080200);

    // Forced no-copier looks at empty unshifted slots
    force_type = 3'd1;
    push("force_nohdr", 1'b0, 8'h00, 24'h3FFFFF, 24'h000000, 1'b0, 1'b0);
    start_dl();
    case1_image();
    end_dl(25'h080200);
    force_type = 3'd0;

    // Short image, nothing captured
    push("all_zero", 1'b0, 8'h00, 24'h3FFFFF, 24'h000000, 1'b0, 1'b0);
    start_dl();
    end_dl(25'h010000);

    // Invalid romsz -> default, ramsz 8 -> 0, region 11h, FastROM map bit
    push("lo_bounds", 1'b0, 8'h00, 24'h3FFFFF, 24'h000000, 1'b1, 1'b1);
    start_dl();
    wr_hdr(25'h007FC0, 8'h30, 8'h00, 8'h0E, 8'h08, 8'h11, 16'h00FF, 16'hFF00);
    end_dl(25'h100000);

    // HiROM+copier, smallest romsz, largest ramsz, region 0Ch
    push("hi_bounds", 1'b1, 8'h21, 24'h03FFFF, 24'h01FFFF, 1'b1, 1'b1);
    start_dl();
    wr_hdr(25'h0101C0, 8'h31, 8'h20, 8'h08, 8'h07, 8'h0C, 16'h0F0F, 16'hF0F0);
    end_dl(25'h040200);

    // Equal scores keep LoROM
    push("tie_lorom", 1'b0, 8'h40, 24'h3FFFFF, 24'h000000, 1'b0, 1'b0);
    start_dl();
    wr_hdr(25'h007FC0, 8'h20, 8'h40, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000);
    wr_hdr(25'h00FFC0, 8'h21, 8'h50, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000);
    end_dl(25'h020000);

    // Reset during EVAL1 aborts with no done
    start_dl();
    case1_image();
    wr_word(25'h0801FE, 16'h0000);
    @(negedge clk_sys);
    ioctl.ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    chk_reset("mid_reset");
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);

    // Restart on a download rise seen in EVAL2
    start_dl();
    case1_image();
    wr_word(25'h0801FE, 16'h0000);
    @(negedge clk_sys);
    ioctl.ioctl_download = 1'b0;
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl.ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      check("restart_busy", busy, 1'b1);
      check("restart_no_done", done, 1'b0);
    end
    check("restart_hold_mask", rom_mask, 24'h3FFFFF);
    push("restart_hirom", 1'b0, 8'h11, 24'h1FFFFF, 24'h000000, 1'b1, 1'b1);
    hirom_image();
    end_dl(25'h200000);

    repeat (10) @(negedge clk_sys);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_done %s: got no done want done", e.name);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
